// File: rtl/iq_ram_axi_lite_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iq_ram_pkg
// Purpose  : Shared constants and types for the iq_ram AXI4-Lite register
//            file: register byte offsets, AXI response codes, the register
//            index type and a helper that maps an index to its response.
// Macro    : IQ_RAM_AXI_SLVERR_EN - unmapped indices answer SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
package iq_ram_pkg;

    localparam logic [4:0] REG0_OFF   = 5'h00;
    localparam logic [4:0] REG1_OFF   = 5'h04;
    localparam logic [4:0] REG2_OFF   = 5'h08;
    localparam logic [4:0] REG3_OFF   = 5'h0C;
    localparam logic [4:0] STATUS_OFF = 5'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word index taken from addr[4:2].
    typedef enum logic [2:0] {
        IDX_REG0   = 3'd0,
        IDX_REG1   = 3'd1,
        IDX_REG2   = 3'd2,
        IDX_REG3   = 3'd3,
        IDX_STATUS = 3'd4,
        IDX_RSVD5  = 3'd5,
        IDX_RSVD6  = 3'd6,
        IDX_RSVD7  = 3'd7
    } reg_idx_e;

    // Response for an access to the given index (same rule for B and R).
    function automatic logic [1:0] idx_resp(input reg_idx_e idx);
        logic [1:0] resp;
        resp = RESP_OKAY;
`ifdef IQ_RAM_AXI_SLVERR_EN
        if (idx inside {IDX_RSVD5, IDX_RSVD6, IDX_RSVD7}) begin
            resp = RESP_SLVERR;
        end
`else
        if (idx inside {IDX_RSVD5, IDX_RSVD6, IDX_RSVD7}) begin
            resp = RESP_OKAY;
        end
`endif
        return resp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iq_ram_axi_lite_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : iq_ram_axi_lite_regs_if
// Purpose  : AXI4-Lite S00_AXI bundle (AW, W, B, AR, R channels).
// Modports : slave  - the register file end
//            master - the driving end (interconnect / BFM)
// Revision : 1.0 - initial release
// ============================================================================
interface iq_ram_axi_lite_regs_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [2:0]                        S_AXI_AWPROT;
    logic                              S_AXI_AWVALID;
    logic                              S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                              S_AXI_WVALID;
    logic                              S_AXI_WREADY;
    logic [1:0]                        S_AXI_BRESP;
    logic                              S_AXI_BVALID;
    logic                              S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [2:0]                        S_AXI_ARPROT;
    logic                              S_AXI_ARVALID;
    logic                              S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                        S_AXI_RRESP;
    logic                              S_AXI_RVALID;
    logic                              S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface
`default_nettype wire

// File: rtl/iq_ram_axi_lite_hold.sv
`default_nettype none
// ============================================================================
// Module   : iq_ram_axi_lite_hold
// Purpose  : One-entry valid/ready holding slot for an AXI request channel.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            valid_i, data_i  - upstream request
//            ready_o          - registered ready (empty and not blocked)
//            block_i          - next-cycle block (pending write response)
//            clear_i          - consume the held entry
//            full_o, data_o   - held entry
// Revision : 1.0 - initial release
// ============================================================================
module iq_ram_axi_lite_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             block_i,
    input  logic             clear_i,
    output logic             ready_o,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);
    logic             full_q,  full_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] data_q,  data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (valid_i && ready_q) begin
            full_d = 1'b1;
            data_d = data_i;
        end
        // Ready is registered, so it is derived from next-state values; this
        // keeps it low in reset and raises it on the first edge after release.
        ready_d = !full_d && !block_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            full_q  <= full_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    assign ready_o = ready_q;
    assign full_o  = full_q;
    assign data_o  = data_q;
endmodule
`default_nettype wire

// File: rtl/iq_ram_axi_lite_regs.sv
`default_nettype none
// ============================================================================
// Module   : iq_ram_axi_lite_regs
// Purpose  : AXI4-Lite slave register file for iq_ram: four R/W control
//            words (0x00-0x0C) and a read-only status word (0x10).
// Ports    : S_AXI_ACLK, S_AXI_ARESETN - clock, async active-low reset
//            s_axi                     - AXI4-Lite slave bundle
//            reg0_o..reg3_o            - current control register contents
//            status_i                  - status word, read at 0x10
// Macro    : IQ_RAM_AXI_SLVERR_EN - unmapped indices 5-7 answer SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
module iq_ram_axi_lite_regs
    import iq_ram_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    iq_ram_axi_lite_regs_if.slave         s_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_o,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] status_i
);
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;

    // ---------------- write path ----------------
    logic [2:0]                       aw_idx;
    logic                             aw_full, aw_ready;
    logic [NB+C_S_AXI_DATA_WIDTH-1:0] w_slot;
    logic                             w_full, w_ready;
    logic                             commit;
    logic                             bvalid_q, bvalid_d;
    logic [1:0]                       bresp_q,  bresp_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]    regs_q [4];
    logic [C_S_AXI_DATA_WIDTH-1:0]    regs_d [4];
    reg_idx_e                         wr_idx;

    assign commit = aw_full && w_full;
    assign wr_idx = reg_idx_e'(aw_idx);

    // BVALID's next state also blocks both slots, so they cannot refill
    // between the commit and the response handshake.
    assign bvalid_d = commit || (bvalid_q && !s_axi.S_AXI_BREADY);

    iq_ram_axi_lite_hold #(.WIDTH(3)) u_aw_hold (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .valid_i (s_axi.S_AXI_AWVALID),
        .data_i  (s_axi.S_AXI_AWADDR[4:2]),
        .block_i (bvalid_d),
        .clear_i (commit),
        .ready_o (aw_ready),
        .full_o  (aw_full),
        .data_o  (aw_idx)
    );

    iq_ram_axi_lite_hold #(.WIDTH(NB + C_S_AXI_DATA_WIDTH)) u_w_hold (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .valid_i (s_axi.S_AXI_WVALID),
        .data_i  ({s_axi.S_AXI_WSTRB, s_axi.S_AXI_WDATA}),
        .block_i (bvalid_d),
        .clear_i (commit),
        .ready_o (w_ready),
        .full_o  (w_full),
        .data_o  (w_slot)
    );

    always_comb begin
        regs_d  = regs_q;
        bresp_d = bresp_q;
        if (commit) begin
            bresp_d = idx_resp(wr_idx);
            // Status and unmapped indices have bit 2 set; writes there drop.
            if (!aw_idx[2]) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_slot[C_S_AXI_DATA_WIDTH + b]) begin
                        regs_d[aw_idx[1:0]][8*b +: 8] = w_slot[8*b +: 8];
                    end
                end
            end
        end
    end

    // ---------------- read path ----------------
    logic                          ar_hs;
    logic                          arready_q, arready_d;
    logic                          rvalid_q,  rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [1:0]                    rresp_q,   rresp_d;
    reg_idx_e                      rd_idx;

    assign rd_idx    = reg_idx_e'(s_axi.S_AXI_ARADDR[4:2]);
    assign ar_hs     = s_axi.S_AXI_ARVALID && arready_q;
    assign rvalid_d  = ar_hs || (rvalid_q && !s_axi.S_AXI_RREADY);
    assign arready_d = !rvalid_d;

    // Sampled from regs_q, so a read racing a commit sees the old value.
    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (ar_hs) begin
            rresp_d = idx_resp(rd_idx);
            case (rd_idx)
                IDX_REG0:   rdata_d = regs_q[0];
                IDX_REG1:   rdata_d = regs_q[1];
                IDX_REG2:   rdata_d = regs_q[2];
                IDX_REG3:   rdata_d = regs_q[3];
                IDX_STATUS: rdata_d = status_i;
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            regs_q    <= '{default: '0};
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            regs_q    <= regs_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s_axi.S_AXI_AWREADY = aw_ready;
    assign s_axi.S_AXI_WREADY  = w_ready;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;

    assign reg0_o = regs_q[0];
    assign reg1_o = regs_q[1];
    assign reg2_o = regs_q[2];
    assign reg3_o = regs_q[3];
endmodule
`default_nettype wire

// File: tb/tb_iq_ram_axi_lite_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_iq_ram_axi_lite_regs
// Purpose  : Directed self-checking bench for iq_ram_axi_lite_regs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iq_ram_axi_lite_regs;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] reg0, reg1, reg2, reg3;
    logic [31:0] status = 32'h00C0FFEE;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef IQ_RAM_AXI_SLVERR_EN
    localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
    localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

    always #5 clk = ~clk;

    iq_ram_axi_lite_regs_if bus ();

    iq_ram_axi_lite_regs dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_axi         (bus),
        .reg0_o        (reg0),
        .reg1_o        (reg1),
        .reg2_o        (reg2),
        .reg3_o        (reg3),
        .status_i      (status)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] reg_port(input int i);
        case (i)
            0: return reg0;
            1: return reg1;
            2: return reg2;
            default: return reg3;
        endcase
    endfunction

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bit aw_go, w_go;
        int n;
        @(posedge clk); #1;
        bus.S_AXI_AWADDR = a; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_BREADY = 1'b1;
        n = 0;
        while ((bus.S_AXI_AWVALID || bus.S_AXI_WVALID) && n < 20) begin
            @(negedge clk);
            aw_go = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_go  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(posedge clk); #1;
            if (aw_go) bus.S_AXI_AWVALID = 1'b0;
            if (w_go)  bus.S_AXI_WVALID  = 1'b0;
            n++;
        end
        if (n >= 20) check_eq("wr_hs_timeout", 32'(bus.S_AXI_AWVALID | bus.S_AXI_WVALID), 32'd0);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        resp = 2'bxx;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (bus.S_AXI_BVALID) begin
                resp = bus.S_AXI_BRESP;
                break;
            end
            n++;
        end
        if (n >= 20) check_eq("wr_b_timeout", 32'(bus.S_AXI_BVALID), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(posedge clk); #1;
        bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b1;
        n = 0;
        while (bus.S_AXI_ARVALID && n < 20) begin
            @(negedge clk);
            if (bus.S_AXI_ARREADY) begin
                @(posedge clk); #1;
                bus.S_AXI_ARVALID = 1'b0;
            end
            n++;
        end
        if (n >= 20) check_eq("rd_ar_timeout", 32'(bus.S_AXI_ARVALID), 32'd0);
        bus.S_AXI_ARVALID = 1'b0;
        d = 'x; resp = 2'bxx;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (bus.S_AXI_RVALID) begin
                d = bus.S_AXI_RDATA; resp = bus.S_AXI_RRESP;
                break;
            end
            n++;
        end
        if (n >= 20) check_eq("rd_r_timeout", 32'(bus.S_AXI_RVALID), 32'd1);
        @(posedge clk); #1;
    endtask

    logic [4:0]  addrs [4] = '{5'h00, 5'h04, 5'h08, 5'h0C};
    logic [31:0] datas [4] = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;

        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b1;

        // Reset state
        #13;
        check_eq("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
        check_eq("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
        check_eq("rst_bvalid",  32'(bus.S_AXI_BVALID), 32'd0);
        check_eq("rst_rvalid",  32'(bus.S_AXI_RVALID), 32'd0);
        check_eq("rst_reg0",    reg0, 32'd0);
        check_eq("rst_rdata",   bus.S_AXI_RDATA, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
        check_eq("post_rst_wready",  32'(bus.S_AXI_WREADY), 32'd1);
        check_eq("post_rst_arready", 32'(bus.S_AXI_ARREADY), 32'd1);

        // Sequential write then read-back
        for (int i = 0; i < 4; i++) begin
            axi_write(addrs[i], datas[i], 4'hF, resp);
            check_eq($sformatf("wr%0d_bresp", i), 32'(resp), 32'd0);
            check_eq($sformatf("wr%0d_port", i), reg_port(i), datas[i]);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(addrs[i], rd, resp);
            check_eq($sformatf("rd%0d_data", i), rd, datas[i]);
            check_eq($sformatf("rd%0d_rresp", i), 32'(resp), 32'd0);
        end

        // Partial strobe on reg2 (currently 0xdead0011)
        axi_write(5'h08, 32'habcd0001, 4'b0011, resp);
        axi_read(5'h08, rd, resp);
        check_eq("strb_rd", rd, 32'hdead0001);
        check_eq("strb_port", reg2, 32'hdead0001);

        // W ahead of AW by 3 cycles, then B backpressure for 5 cycles
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_WDATA = 32'h55AA55AA; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        check_eq("wfirst_wready", 32'(bus.S_AXI_WREADY), 32'd1);
        @(posedge clk); #1; bus.S_AXI_WVALID = 1'b0;
        @(negedge clk);
        check_eq("wfirst_wready_low", 32'(bus.S_AXI_WREADY), 32'd0);
        check_eq("wfirst_no_b", 32'(bus.S_AXI_BVALID), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        bus.S_AXI_AWADDR = 5'h04; bus.S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        check_eq("wfirst_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
        @(posedge clk); #1; bus.S_AXI_AWVALID = 1'b0;
        @(negedge clk);
        check_eq("wfirst_b_not_yet", 32'(bus.S_AXI_BVALID), 32'd0);
        @(negedge clk);
        check_eq("wfirst_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
        check_eq("wfirst_port", reg1, 32'h55AA55AA);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_bvalid",  32'(bus.S_AXI_BVALID), 32'd1);
            check_eq("bp_bresp",   32'(bus.S_AXI_BRESP), 32'd0);
            check_eq("bp_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
            check_eq("bp_wready",  32'(bus.S_AXI_WREADY), 32'd0);
        end
        @(posedge clk); #1; bus.S_AXI_BREADY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_released_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
        check_eq("bp_released_awready", 32'(bus.S_AXI_AWREADY), 32'd1);

        // R backpressure on reg0
        @(posedge clk); #1;
        bus.S_AXI_RREADY = 1'b0; bus.S_AXI_ARADDR = 5'h00; bus.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        check_eq("rbp_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
        @(posedge clk); #1; bus.S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("rbp_rvalid",  32'(bus.S_AXI_RVALID), 32'd1);
            check_eq("rbp_rdata",   bus.S_AXI_RDATA, 32'h0101FFFF);
            check_eq("rbp_arready_low", 32'(bus.S_AXI_ARREADY), 32'd0);
        end
        @(posedge clk); #1; bus.S_AXI_RREADY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rbp_released", 32'(bus.S_AXI_RVALID), 32'd0);

        // Status word: write dropped, read returns status_i
        axi_write(5'h10, 32'h12345678, 4'hF, resp);
        check_eq("status_wr_bresp", 32'(resp), 32'd0);
        axi_read(5'h10, rd, resp);
        check_eq("status_rd", rd, 32'h00C0FFEE);
        check_eq("status_rresp", 32'(resp), 32'd0);
        check_eq("status_reg0_kept", reg0, 32'h0101FFFF);

        // Unmapped indices
        axi_read(5'h18, rd, resp);
        check_eq("unmap_rd", rd, 32'd0);
        check_eq("unmap_rresp", 32'(resp), 32'(UNMAP_RESP));
        axi_write(5'h14, 32'hFFFFFFFF, 4'hF, resp);
        check_eq("unmap_bresp", 32'(resp), 32'(UNMAP_RESP));
        check_eq("unmap_reg3_kept", reg3, 32'hbeef0011);
        check_eq("unmap_reg1_kept", reg1, 32'h55AA55AA);

        // Reset while BVALID is held
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_AWADDR = 5'h0C; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h11112222; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
        check_eq("mid_reg3", reg3, 32'h11112222);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
        check_eq("mid_rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
        check_eq("mid_rst_reg3", reg3, 32'd0);
        @(negedge clk); rst_n = 1'b1; bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        check_eq("after_rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
        for (int i = 0; i < 4; i++) begin
            axi_read(addrs[i], rd, resp);
            check_eq($sformatf("after_rst_rd%0d", i), rd, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
`default_nettype wire
